// File: rtl/sig_profile_sink.sv
// -----------------------------------------------------------------------------
// sig_profile_sink
//
// Ping-pong frame buffer for the signal core's profile stream (mel bins plus
// the ZCR word). The writer fills one bank while the reader drains the other.
// A bank becomes visible to the reader once its last word has been accepted,
// and it is handed back to the writer when the reader pulses frame_release.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset (control state and rd_data)
//   init           synchronous clear of pointers, full flags and frame counter
//   profile_data   16-bit profile word from the signal core
//   profile_valid  profile_data valid
//   profile_rdy    sink can accept a word this cycle
//   frame_valid    a complete frame is held in the presented bank
//   frame_bank     index (0/1) of the presented bank
//   rd_addr        word index within the presented frame
//   rd_data        registered read data (0 for rd_addr >= FRAME_WORDS)
//   frame_release  one-cycle pulse: reader is done with the presented frame
//   frame_count    completed frames since reset/init, wraps modulo 256
// -----------------------------------------------------------------------------
module sig_profile_sink #(
  parameter int FRAME_WORDS = 32,
  parameter int ADDR_W      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic [15:0]       profile_data,
  input  logic              profile_valid,
  output logic              profile_rdy,
  output logic              frame_valid,
  output logic              frame_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_data,
  input  logic              frame_release,
  output logic [7:0]        frame_count
);

  localparam int DATA_W = 16;
  localparam int PTR_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(FRAME_WORDS - 1);
  // One bit wider than rd_addr so FRAME_WORDS == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   ADDR_LIM = (ADDR_W + 1)'(FRAME_WORDS);

  logic [DATA_W-1:0] mem [2][FRAME_WORDS];

  logic [1:0]        full;
  logic              wr_bank;
  logic              rd_bank;
  logic [PTR_W-1:0]  wr_ptr;

  logic              accept;
  logic              frame_done;
  logic              release_ok;
  logic [PTR_W-1:0]  rd_idx;
  logic              rd_in_range;
  logic [DATA_W-1:0] rd_data_p1;

  // The writer only stalls when the bank it is pointing at still holds an
  // unreleased frame, i.e. both banks are full.
  assign profile_rdy = !full[wr_bank] && !init;
  assign accept      = profile_valid && profile_rdy;
  assign frame_done  = accept && (wr_ptr == LAST_PTR);

  // A release without a presented frame is ignored.
  assign release_ok  = frame_release && full[rd_bank];

  assign frame_valid = full[rd_bank];
  assign frame_bank  = rd_bank;

  assign rd_idx      = rd_addr[PTR_W-1:0];
  assign rd_in_range = {1'b0, rd_addr} < ADDR_LIM;

  // Completion always targets wr_bank (empty) and release always targets
  // rd_bank (full), so when both happen in one cycle they touch different
  // full[] bits and both take effect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full        <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wr_ptr      <= '0;
      frame_count <= '0;
    end else if (init) begin
      full        <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wr_ptr      <= '0;
      frame_count <= '0;
    end else begin
      if (accept) begin
        if (frame_done) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_ptr        <= '0;
          frame_count   <= frame_count + 8'd1;
        end else begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
      end
      if (release_ok) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

  // Frame storage is deliberately not cleared by reset or init.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_bank][wr_ptr] <= profile_data;
    end
  end

  // ---- read stage p0 -> p1: address sampled, data registered ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_p1 <= '0;
    end else if (rd_in_range) begin
      rd_data_p1 <= mem[rd_bank][rd_idx];
    end else begin
      rd_data_p1 <= '0;
    end
  end

  assign rd_data = rd_data_p1;

endmodule

// File: tb/tb_sig_profile_sink.sv
// -----------------------------------------------------------------------------
// tb_sig_profile_sink
//
// Self-checking bench for sig_profile_sink. Accepted words are pushed into a
// scoreboard as a frame builds up; a completed frame moves to the expected
// queue, and reads of the presented bank are compared against its front.
// A release pops the front frame. The model tracks only how many complete
// frames are held, which bank is presented and the frame count.
// -----------------------------------------------------------------------------
module tb_sig_profile_sink;

  localparam int FW = 32;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          init;
  logic [15:0]   profile_data;
  logic          profile_valid;
  logic          profile_rdy;
  logic          frame_valid;
  logic          frame_bank;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_data;
  logic          frame_release;
  logic [7:0]    frame_count;

  always #5 clk = ~clk;

  sig_profile_sink #(
    .FRAME_WORDS(FW),
    .ADDR_W     (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .init         (init),
    .profile_data (profile_data),
    .profile_valid(profile_valid),
    .profile_rdy  (profile_rdy),
    .frame_valid  (frame_valid),
    .frame_bank   (frame_bank),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .frame_release(frame_release),
    .frame_count  (frame_count)
  );

  int          n_chk = 0;
  int          n_err = 0;

  logic [15:0] exp_q[$];
  logic [15:0] part_q[$];
  int          m_held;
  bit          m_rbank;
  int          m_fc;

  bit          auto_rd;
  int          rd_k;
  int          rd_pend;
  bit          last_acc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    part_q.delete();
    m_held  = 0;
    m_rbank = 1'b0;
    m_fc    = 0;
    rd_k    = 0;
    rd_pend = -1;
  endtask

  // One clock cycle, entered and left 1 time unit after a rising edge.
  task automatic tick();
    bit          acc;
    bit          rel;
    bit          ini;
    logic [15:0] d;
    if (auto_rd) begin
      if (m_held > 0 && rd_k < FW) begin
        rd_addr       = AW'(rd_k);
        rd_pend       = rd_k;
        rd_k++;
        frame_release = 1'b0;
      end else if (m_held > 0) begin
        frame_release = 1'b1;
        rd_pend       = -1;
      end else begin
        frame_release = 1'b0;
        rd_pend       = -1;
      end
    end else begin
      rd_pend = -1;
    end
    #1;
    ini = init;
    check_eq("rdy", profile_rdy, (m_held < 2) && !ini);
    check_eq("fvalid", frame_valid, m_held > 0);
    check_eq("fbank", frame_bank, m_rbank);
    check_eq("fcount", frame_count, m_fc);
    acc = profile_valid && (m_held < 2) && !ini;
    rel = frame_release && (m_held > 0) && !ini;
    d   = profile_data;
    @(posedge clk);
    #1;
    last_acc = acc;
    if (ini) begin
      model_clear();
    end else begin
      if (acc) begin
        part_q.push_back(d);
        if (part_q.size() == FW) begin
          foreach (part_q[i]) exp_q.push_back(part_q[i]);
          part_q.delete();
          m_held++;
          m_fc = (m_fc + 1) % 256;
        end
      end
      if (rel) begin
        repeat (FW) void'(exp_q.pop_front());
        m_held--;
        m_rbank = ~m_rbank;
        rd_k    = 0;
      end
      if (rd_pend >= 0) begin
        if (rd_pend < exp_q.size())
          check_eq("rd_auto", rd_data, exp_q[rd_pend]);
        else
          check_eq("rd_q_short", exp_q.size(), rd_pend + 1);
      end
    end
  endtask

  task automatic send(input logic [15:0] d);
    int n;
    n = 0;
    profile_valid = 1'b1;
    profile_data  = d;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 200);
    check_eq("send_accepted", last_acc, 1'b1);
    profile_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    auto_rd       = 1'b1;
    profile_valid = 1'b0;
    while (m_held > 0 && n < 400) begin
      tick();
      n++;
    end
    check_eq("drain_fvalid", frame_valid, 1'b0);
    auto_rd       = 1'b0;
    frame_release = 1'b0;
  endtask

  task automatic do_init();
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b0;
    init          = 1'b0;
    profile_valid = 1'b0;
    profile_data  = '0;
    rd_addr       = '0;
    frame_release = 1'b0;
    auto_rd       = 1'b0;
    last_acc      = 1'b0;
    model_clear();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_fvalid", frame_valid, 1'b0);
    check_eq("rst_fbank", frame_bank, 1'b0);
    check_eq("rst_rdy", profile_rdy, 1'b1);
    check_eq("rst_fcount", frame_count, 8'd0);
    check_eq("rst_rddata", rd_data, 16'd0);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // Release with nothing presented is ignored
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
    check_eq("rel_empty_bank", frame_bank, 1'b0);

    // One frame of words 0..31, back-to-back
    for (int k = 0; k < FW; k++) send(16'(k));
    check_eq("t029_fvalid", frame_valid, 1'b1);
    check_eq("t029_fbank", frame_bank, 1'b0);
    check_eq("t029_fcount", frame_count, 8'd1);
    for (int k = 0; k < FW; k++) begin
      rd_addr = AW'(k);
      tick();
      check_eq("t029_rd", rd_data, k);
    end
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
    check_eq("t029_rel_bank", frame_bank, 1'b1);

    // Both banks full: writer stalls until a release
    do_init();
    for (int k = 0; k < 2 * FW; k++) send(16'h1000 + 16'(k));
    check_eq("t030_rdy_low", profile_rdy, 1'b0);
    profile_valid = 1'b1;
    profile_data  = 16'h1040;
    repeat (3) tick();
    check_eq("t030_fbank_hold", frame_bank, 1'b0);
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
    check_eq("t030_fbank", frame_bank, 1'b1);
    check_eq("t030_rdy", profile_rdy, 1'b1);
    tick();
    profile_valid = 1'b0;
    auto_rd = 1'b1;
    for (int k = 1; k < FW; k++) send(16'h1040 + 16'(k));
    drain();

    // Release of bank 0 in the cycle that completes bank 1
    do_init();
    for (int k = 0; k < FW; k++) send(16'h3000 + 16'(k));
    for (int k = 0; k < FW - 1; k++) send(16'h3100 + 16'(k));
    frame_release = 1'b1;
    send(16'h3100 + 16'(FW - 1));
    frame_release = 1'b0;
    check_eq("t031_fvalid", frame_valid, 1'b1);
    check_eq("t031_fbank", frame_bank, 1'b1);
    check_eq("t031_fcount", frame_count, 8'd2);
    check_eq("t031_rdy", profile_rdy, 1'b1);
    drain();

    // init mid-frame discards the partial frame
    do_init();
    for (int k = 0; k < 10; k++) send(16'h2000 + 16'(k));
    init          = 1'b1;
    profile_valid = 1'b1;
    profile_data  = 16'h20FF;
    #1;
    check_eq("t032_rdy_init", profile_rdy, 1'b0);
    tick();
    init          = 1'b0;
    profile_valid = 1'b0;
    auto_rd       = 1'b1;
    for (int k = 0; k < FW; k++) send(16'h2100 + 16'(k));
    check_eq("t032_fcount", frame_count, 8'd1);
    check_eq("t032_fbank", frame_bank, 1'b0);
    drain();

    // Asynchronous reset between edges with bank 0 full and bank 1 partial
    do_init();
    for (int k = 0; k < FW; k++) send(16'hA000 + 16'(k));
    for (int k = 0; k < 5; k++) send(16'hC000 + 16'(k));
    rd_addr = AW'(3);
    tick();
    check_eq("t033_rd_pre", rd_data, 16'hA003);
    rd_addr = AW'(40);
    tick();
    check_eq("t033_rd_oor_full", rd_data, 16'd0);
    rd_addr = AW'(3);
    tick();
    #2 rst = 1'b0;
    #1;
    check_eq("t033_fvalid", frame_valid, 1'b0);
    check_eq("t033_rddata", rd_data, 16'd0);
    check_eq("t033_fbank", frame_bank, 1'b0);
    check_eq("t033_rdy", profile_rdy, 1'b1);
    check_eq("t033_fcount", frame_count, 8'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rd_addr = AW'(40);
    tick();
    check_eq("t033_rd_oor", rd_data, 16'd0);
    auto_rd = 1'b1;
    for (int k = 0; k < FW; k++) send(16'hB000 + 16'(k));
    drain();

    // 256 frames with immediate release, frame_count wraps
    do_init();
    auto_rd = 1'b1;
    for (int i = 0; i < 256 * FW; i++) send(16'(i * 37 + 5));
    check_eq("t034_fcount_wrap", frame_count, 8'd0);
    drain();
    check_eq("t034_sb_empty", exp_q.size() + part_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sig_profile_sink.md
SIG_PROFILE_SINK -- requirements
Module: sig_profile_sink

Interface
REQ-001 Parameter FRAME_WORDS, default 32, profile words per frame (mel bins plus ZCR word).
REQ-002 Parameter ADDR_W, default 5, read-address width; SHALL satisfy 2^ADDR_W >= FRAME_WORDS.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 init  input  1  synchronous clear of pointers, flags and counter.
REQ-006 profile_data  input  16  profile word from the signal core.
REQ-007 profile_valid  input  1  profile_data valid.
REQ-008 profile_rdy  output  1  sink can accept a word this cycle.
REQ-009 frame_valid  output  1  a complete frame is held for the reader.
REQ-010 frame_bank  output  1  bank index (0/1) of the frame being presented.
REQ-011 rd_addr  input  ADDR_W  word index within the presented frame.
REQ-012 rd_data  output  16  registered read data.
REQ-013 frame_release  input  1  one-cycle pulse: reader has finished the presented frame.
REQ-014 frame_count  output  8  completed frames since reset/init, wraps 255->0.

Function
REQ-015 Storage SHALL be two banks (ping-pong) of FRAME_WORDS x 16 bits; state: full[1:0], wr_bank, wr_ptr, rd_bank.
REQ-016 profile_rdy SHALL equal !full[wr_bank] && !init (combinational from registered state).
REQ-017 A word SHALL be accepted only on a cycle with profile_valid && profile_rdy; it is written to bank wr_bank at wr_ptr and wr_ptr increments.
REQ-018 On accepting the word at wr_ptr == FRAME_WORDS-1: full[wr_bank] set, wr_bank toggles, wr_ptr returns to 0, frame_count increments (mod 256), all on the same edge.
REQ-019 profile_data/profile_valid SHALL be ignored while profile_rdy is low; no word is dropped or duplicated.
REQ-020 frame_valid SHALL equal full[rd_bank]; frame_bank SHALL equal rd_bank; frame_valid therefore rises on the edge that accepts the last word of a frame destined for rd_bank.
REQ-021 frame_release while frame_valid: clear full[rd_bank], toggle rd_bank on that edge; frame_release while !frame_valid SHALL be ignored.
REQ-022 Completion of one bank and release of the other in the same cycle SHALL both take effect.
REQ-023 rd_data SHALL present mem[rd_bank][rd_addr] one cycle after rd_addr is sampled; rd_addr >= FRAME_WORDS returns 0.
REQ-024 A release SHALL take effect for reads sampled on the following cycle; rd_data is not required to be valid while frame_valid is low.
REQ-025 With both banks full, profile_rdy SHALL stay low until a release; the first word after the release goes to the released bank.
REQ-026 init SHALL override all other activity that cycle: full = 00, wr_bank = rd_bank = 0, wr_ptr = 0, frame_count = 0; memory contents are not cleared; a partial frame is discarded.

Reset
REQ-027 While rst is low: full = 00, wr_bank = rd_bank = 0, wr_ptr = 0, frame_count = 0, rd_data = 0, hence frame_valid = 0, frame_bank = 0 and profile_rdy = 1 (init low).
REQ-028 Reset asserted mid-frame SHALL discard the partial frame immediately, without waiting for a clock edge; the first word accepted after release of reset goes to bank 0, address 0.

Verification
REQ-029 Stream words 0..31 back-to-back, valid always high -> frame_valid = 1 and frame_bank = 0 on the edge that accepts word 31, frame_count = 1, rd_addr = k returns k one cycle later.
REQ-030 Stream 64 words without release -> profile_rdy falls on the 64th accept edge; word 64 is held with valid high; release pulse -> frame_bank = 1 next cycle, profile_rdy = 1, word 64 lands in bank 0 address 0.
REQ-031 Release of bank 0 on the same cycle as acceptance of bank 1's last word -> full = 10, rd_bank = 1, frame_valid stays 1, frame_count = 2.
REQ-032 Assert init after 10 words of a frame -> profile_rdy = 0 during init; the next 32 words form a complete frame in bank 0, and frame_count = 1 afterwards.
REQ-033 Drive rst low asynchronously between clock edges while bank 0 is full -> frame_valid and rd_data drop to 0 immediately; rd_addr = 40 (>= FRAME_WORDS) after reset returns 0.
REQ-034 Complete 256 frames with immediate release -> frame_count wraps 255 -> 0; no word is lost, checked by a scoreboard of the 8192-word sequence.
